// File: rtl/activation_window_packer.sv
// rtl/activation_window_packer.sv - quantize convolution outputs and pack SIZE*SIZE pooling windows
//
// Purpose:
//   Each accepted beat carries one window position for LANES channels. Every
//   lane is ReLU'd, right-shifted by the window's shift amount and saturated
//   to IFM_BIT unsigned. The beats are collected in a staging buffer. On the
//   last position the full window is copied to ACTIVATION, and out_valid
//   pulses for one cycle.
//
// Optional feature:
//   ACT_ROUND_EN - when defined, adds 2^(shift-1) before the shift (round half up).
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   ofm_valid   in   one window position present on OFM this cycle
//   OFM         in   LANES x OFM_BIT signed values, lane l at [l*OFM_BIT +: OFM_BIT]
//   quant_shift in   right-shift amount, sampled on each window's position-0 beat
//   win_clr     in   discard partial window, clear sat_flag
//   out_valid   out  one-cycle pulse, ACTIVATION holds a complete window
//   ACTIVATION  out  lane l, position p at [(l*SIZE*SIZE+p)*IFM_BIT +: IFM_BIT]
//   sat_flag    out  sticky saturation indicator

module activation_window_packer #(
  parameter int SIZE    = 2,
  parameter int LANES   = 8,
  parameter int OFM_BIT = 29,
  parameter int IFM_BIT = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ofm_valid,
  input  logic [LANES*OFM_BIT-1:0]          OFM,
  input  logic [4:0]                        quant_shift,
  input  logic                              win_clr,
  output logic                              out_valid,
  output logic [LANES*SIZE*SIZE*IFM_BIT-1:0] ACTIVATION,
  output logic                              sat_flag
);

  localparam int WIN = SIZE * SIZE;
  localparam int PW  = (WIN > 1) ? $clog2(WIN) : 1;
  // Wide enough that a 31-bit shift or rounding constant never overflows.
  localparam int XW  = OFM_BIT + 32;
  localparam int AW  = LANES * WIN * IFM_BIT;
  localparam logic [PW-1:0] LAST_POS = PW'(WIN - 1);
  localparam logic [XW-1:0] MAX_VAL  = {{(XW-IFM_BIT){1'b0}}, {IFM_BIT{1'b1}}};

  logic [PW-1:0]      pos_q, pos_d, cur_pos;
  logic [4:0]         shift_q, shift_d, cur_shift;
  logic               out_valid_q;
  logic               sat_q, sat_d;
  logic [AW-1:0]      act_q, act_d;
  logic [IFM_BIT-1:0] stage_q [WIN][LANES];
  logic [IFM_BIT-1:0] quant [LANES];
  logic [LANES-1:0]   lane_sat;
  logic               complete;

  // Returns {saturated, value}.
  function automatic logic [IFM_BIT:0] quantize(input logic [OFM_BIT-1:0] v,
                                                 input logic [4:0]         s);
    logic [XW-1:0]      mag;
    logic [XW-1:0]      shifted;
    logic [IFM_BIT:0]   res;
    res = '0;
    if (!v[OFM_BIT-1]) begin
      mag = XW'(v);
`ifdef ACT_ROUND_EN
      if (s != 5'd0) mag = mag + (XW'(1) << (s - 5'd1));
`endif
      shifted = mag >> s;
      if (shifted > MAX_VAL) res = {1'b1, {IFM_BIT{1'b1}}};
      else                   res = {1'b0, shifted[IFM_BIT-1:0]};
    end
    return res;
  endfunction

  // win_clr restarts the window, so a beat in the same cycle lands at position 0
  // and (being position 0) uses the live quant_shift rather than the latched one.
  always_comb begin
    cur_pos   = win_clr ? '0 : pos_q;
    cur_shift = (cur_pos == '0) ? quant_shift : shift_q;
  end

  always_comb begin
    logic [IFM_BIT:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      r           = quantize(OFM[l*OFM_BIT +: OFM_BIT], cur_shift);
      quant[l]    = r[IFM_BIT-1:0];
      lane_sat[l] = r[IFM_BIT];
    end
  end

  always_comb begin
    complete = ofm_valid && (cur_pos == LAST_POS) && !win_clr;
    pos_d    = cur_pos;
    if (ofm_valid) pos_d = (cur_pos == LAST_POS) ? '0 : cur_pos + PW'(1);
    shift_d  = (ofm_valid && cur_pos == '0) ? quant_shift : shift_q;
    sat_d    = win_clr ? 1'b0 : (sat_q | (ofm_valid & (|lane_sat)));
  end

  // Completed window = staging buffer with the current (last) beat merged in.
  always_comb begin
    act_d = act_q;
    for (int p = 0; p < WIN; p++) begin
      for (int l = 0; l < LANES; l++) begin
        act_d[(l*WIN+p)*IFM_BIT +: IFM_BIT] = (PW'(p) == cur_pos) ? quant[l] : stage_q[p][l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q       <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      act_q       <= '0;
      for (int p = 0; p < WIN; p++) begin
        for (int l = 0; l < LANES; l++) stage_q[p][l] <= '0;
      end
    end else begin
      pos_q       <= pos_d;
      shift_q     <= shift_d;
      out_valid_q <= complete;
      sat_q       <= sat_d;
      if (complete) act_q <= act_d;
      if (ofm_valid) begin
        for (int l = 0; l < LANES; l++) stage_q[cur_pos][l] <= quant[l];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign ACTIVATION = act_q;
  assign sat_flag   = sat_q;

endmodule

// File: doc/activation_window_packer.md
ACTIVATION_WINDOW_PACKER -- requirements
Module: activation_window_packer

Interface
REQ-001 Parameter SIZE, default 2, meaning pooling window edge; window = SIZE*SIZE pixels.
REQ-002 Parameter LANES, default 8, meaning channels packed per output beat (matches downstream pooling lane count).
REQ-003 Parameter OFM_BIT, default 29, meaning signed width of each convolution output value.
REQ-004 Parameter IFM_BIT, default 8, meaning unsigned width of each quantized activation.
REQ-005 Port clk  input  1  the single clock, rising edge.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port ofm_valid  input  1  one pixel position of the window present on OFM this cycle.
REQ-008 Port OFM  input  LANES*OFM_BIT  signed values; lane l at [l*OFM_BIT +: OFM_BIT].
REQ-009 Port quant_shift  input  5  right-shift amount for quantization.
REQ-010 Port win_clr  input  1  synchronous discard of any partial window.
REQ-011 Port out_valid  output  1  one-cycle pulse: ACTIVATION holds a complete window.
REQ-012 Port ACTIVATION  output  LANES*SIZE*SIZE*IFM_BIT  packed window; lane l, position p at [(l*SIZE*SIZE+p)*IFM_BIT +: IFM_BIT].
REQ-013 Port sat_flag  output  1  sticky: at least one value saturated since reset or win_clr.

Function
REQ-014 Each accepted beat, each lane SHALL be quantized: negative -> 0 (ReLU); else value >> shift_q (logical); result > 2^IFM_BIT-1 -> 2^IFM_BIT-1.
REQ-015 shift_q SHALL be quant_shift latched on the window's position-0 beat and used for all SIZE*SIZE beats of that window.
REQ-016 Position counter pos SHALL run 0..SIZE*SIZE-1, increment on each ofm_valid beat, wrap to 0 after last position.
REQ-017 Quantized lane values of beat at position p SHALL be written to a staging buffer at position p.
REQ-018 On the beat with pos = SIZE*SIZE-1, ACTIVATION SHALL update with the full window and out_valid SHALL assert the next cycle, for exactly one cycle (latency 1 from last beat).
REQ-019 ACTIVATION SHALL hold its value between out_valid pulses; never X after reset.
REQ-020 No backpressure: ofm_valid in the cycle out_valid is high SHALL be accepted as position 0 of the next window; back-to-back windows at full rate SHALL be supported.
REQ-021 Gaps (ofm_valid low) between beats of a window SHALL be allowed; pos holds.
REQ-022 win_clr SHALL reset pos to 0, clear sat_flag, and suppress any pending window; ofm_valid in the same cycle SHALL be accepted as position 0 of a new window.
REQ-023 win_clr in the cycle of the last beat SHALL cancel that window: no out_valid, ACTIVATION unchanged.
REQ-024 sat_flag SHALL set in the cycle after any lane saturates on an accepted beat; win_clr in that cycle takes priority (flag stays 0).

Reset
REQ-025 rst_n low SHALL asynchronously force out_valid=0, ACTIVATION=0, sat_flag=0, pos=0, shift_q=0, staging buffer=0.
REQ-026 Reset mid-window SHALL discard the partial window; first beat after release is position 0.

Configuration
REQ-027 Macro ACT_ROUND_EN defined: before shift, add 2^(shift_q-1) when shift_q>0 (round half up), then saturate.
REQ-028 Macro ACT_ROUND_EN undefined: pure truncation per REQ-014; no rounding adder synthesized.

Verification
REQ-029 Shift=0, four beats, all lanes of beat p = 10*p+1 -> one cycle after 4th beat out_valid=1, each lane's positions = 1,11,21,31.
REQ-030 Shift=4, lane values -5, 0x1000, 0x7FFFFF, 40 -> quantized 0, 255 (sat), 255 (sat), 2 (3 with ACT_ROUND_EN); sat_flag=1.
REQ-031 Eight consecutive ofm_valid beats -> out_valid pulses exactly twice, 4 cycles apart, correct packing for both windows.
REQ-032 Two beats, win_clr, four beats -> single out_valid, contents from last four beats only; sat_flag=0.
REQ-033 quant_shift changed from 0 to 3 after beat 0 -> all four positions quantized with shift 0.
REQ-034 rst_n pulsed low after beat 2 -> outputs 0 immediately; next four beats produce a correct window.
